// File: rtl/fmap_writer.sv
// fmap_writer
//   Write side of the feature-map memory. Accepts one output pixel per
//   handshake in raster order. It pairs each even-column pixel with the
//   odd-column pixel that follows it and issues one dual-address write per
//   pair. A full WIDTH x HEIGHT map is filled per frame.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, begins a frame when idle
//   in_valid   pixel present on in_data
//   in_ready   writer accepts a pixel this cycle (RUN only)
//   in_data    OC+1 channels, channel c at [c*DW +: DW]
//   wr_en      write strobe for both addresses (registered)
//   wr_addr1   address of even-column pixel (registered)
//   wr_addr2   wr_addr1 + 1 (registered)
//   wr_data1   even-column pixel data (registered)
//   wr_data2   odd-column pixel data (registered)
//   busy       frame in progress (RUN / FLUSH)
//   done       one-cycle pulse after the last pair is written
//
// Build option
//   FMAP_WRITER_RELU_EN  when defined, negative channel values are clamped
//                        to 0 at acceptance. Otherwise data is written
//                        bit-exact.

module fmap_writer #(
  parameter int OC     = 15,
  parameter int DW     = 8,
  parameter int WIDTH  = 14,
  parameter int HEIGHT = 14,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(OC+1)*DW-1:0] in_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr1,
  output logic [ADDR_W-1:0]    wr_addr2,
  output logic [(OC+1)*DW-1:0] wr_data1,
  output logic [(OC+1)*DW-1:0] wr_data2,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = (OC + 1) * DW;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [PW-1:0]   hold;

  logic            accept;
  logic [PW-1:0]   px;
  logic [31:0]     addr_full;

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN) || (state == S_FLUSH);
  assign done     = (state == S_DONE);
  assign accept   = in_valid & in_ready;

  // Channel filter applied once at acceptance, so the hold and direct
  // paths see identical treatment.
  always_comb begin
    px = in_data;
`ifdef FMAP_WRITER_RELU_EN
    for (int unsigned c = 0; c <= OC; c++) begin
      if (in_data[c*DW + DW - 1])
        px[c*DW +: DW] = '0;
    end
`endif
  end

  // The even-column partner sits at col-1. Compute at full width, then
  // truncate to the port width.
  always_comb begin
    addr_full = 32'(row) * 32'(WIDTH) + 32'(col) - 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      hold     <= '0;
      wr_en    <= 1'b0;
      wr_addr1 <= '0;
      wr_addr2 <= '0;
      wr_data1 <= '0;
      wr_data2 <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row   <= '0;
            col   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (!col[0]) begin
              hold <= px;
            end else begin
              wr_en    <= 1'b1;
              wr_addr1 <= ADDR_W'(addr_full);
              wr_addr2 <= ADDR_W'(addr_full + 32'd1);
              wr_data1 <= hold;
              wr_data2 <= px;
            end
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
              if (row == ROW_LAST)
                state <= S_FLUSH;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_FLUSH: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_writer.sv
module tb_fmap_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         wr_en;
  logic [7:0]   wr_addr1;
  logic [7:0]   wr_addr2;
  logic [127:0] wr_data1;
  logic [127:0] wr_data2;
  logic         busy;
  logic         done;

  fmap_writer #(
    .OC(15), .DW(8), .WIDTH(14), .HEIGHT(14), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_data1(wr_data1),
    .wr_data2(wr_data2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [127:0] d1;
    logic [127:0] d2;
  } wr_t;

  wr_t wq[$];
  int  cyc      = 0;
  int  done_cnt = 0;
  int  acc_cyc  = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && wr_en) begin
      wr_t w;
      w.cyc = cyc; w.a1 = wr_addr1; w.a2 = wr_addr2;
      w.d1 = wr_data1; w.d2 = wr_data2;
      wq.push_back(w);
    end
    if (rst && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pix(input int idx);
    logic [127:0] r;
    for (int c = 0; c < 16; c++)
      r[c*8 +: 8] = (idx == 0) ? 8'h11 : (idx == 1) ? 8'h22 : 8'(idx * 7 + c * 13);
    return r;
  endfunction

  function automatic logic [127:0] exp_px(input logic [127:0] d);
    logic [127:0] r;
    r = d;
`ifdef FMAP_WRITER_RELU_EN
    for (int c = 0; c < 16; c++)
      if (r[c*8 + 7]) r[c*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  // Present one pixel after 'gap' idle cycles; returns just after the
  // accepting edge with acc_cyc set.
  task automatic send(input logic [127:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    logic [127:0] pd, pe;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check("reset_outs", {in_ready, wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2, busy, done}, '0);
    #1 rst = 1'b1;

    // Idle with no start: nothing moves.
    bad = 1'b0;
    repeat (20) begin
      tick();
      bad = bad | in_ready | busy | wr_en | done;
    end
    check("idle_quiet", bad, 1'b0);

    // Frame 1
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    check("run_flags", {busy, in_ready}, 2'b11);

    send(pix(0), 0);
    send(pix(1), 0);
    check("pair0_now", {wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2},
          {1'b1, 8'd0, 8'd1, exp_px(pix(0)), exp_px(pix(1))});
    tick();
    check("pair0_one_cycle", wr_en, 1'b0);
    check("pair0_latency", wq[0].cyc, acc_cyc);

    for (int i = 2; i < 16; i++) send(pix(i), 0);
    tick();
    check("wrap_count", wq.size(), 8);
    check("wrap_addr", {wq[7].a1, wq[7].a2}, {8'd14, 8'd15});

    // start while running must be ignored
    start = 1'b1; tick(); start = 1'b0;

    for (int i = 16; i < 196; i++) send(pix(i), $urandom_range(0, 2));
    check("flush_state", {in_ready, wr_en, busy, done}, 4'b0110);
    check("last_addr", {wr_addr1, wr_addr2}, {8'd194, 8'd195});
    tick();
    check("done_state", {done, busy, in_ready, wr_en}, 4'b1000);
    tick();
    check("done_single", done, 1'b0);
    check("frame_writes", wq.size(), 98);
    check("done_count", done_cnt, 1);
    for (int k = 0; k < wq.size(); k++)
      check($sformatf("wr_%0d", k), {wq[k].a1, wq[k].a2, wq[k].d1, wq[k].d2},
            {8'(2*k), 8'(2*k+1), exp_px(pix(2*k)), exp_px(pix(2*k+1))});

    // in_valid while idle is ignored
    in_valid = 1'b1; in_data = pix(7);
    bad = 1'b0;
    repeat (5) begin
      tick();
      bad = bad | in_ready;
    end
    in_valid = 1'b0;
    check("idle_ready_low", bad, 1'b0);
    check("idle_no_write", wq.size(), 98);

    // Abort: start together with in_valid (pixel not taken), 3 pixels, reset
    wq.delete();
    start = 1'b1; in_valid = 1'b1; in_data = pix(250);
    tick();
    start = 1'b0; in_valid = 1'b0;
    send(pix(100), 0);
    send(pix(101), 0);
    send(pix(102), 0);
    #2 rst = 1'b0;
    #1;
    check("abort_rst_outs", {in_ready, wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2, busy, done}, '0);
    check("abort_first", {wq[0].a1, wq[0].a2, wq[0].d1, wq[0].d2},
          {8'd0, 8'd1, exp_px(pix(100)), exp_px(pix(101))});
    #3 rst = 1'b1;
    repeat (3) tick();

    pd = '0; pd[7:0] = 8'hF0;
    pe = '0; pe[7:0] = 8'h05;
    start = 1'b1; tick(); start = 1'b0;
    send(pd, 0);
    send(pe, 0);
    tick();
    check("abort_no_held", wq.size(), 2);
    check("restart_pair", {wq[1].a1, wq[1].a2, wq[1].d1, wq[1].d2},
          {8'd0, 8'd1, exp_px(pd), exp_px(pe)});
`ifdef FMAP_WRITER_RELU_EN
    check("relu_ch0", {wq[1].d1[7:0], wq[1].d2[7:0]}, {8'h00, 8'h05});
`else
    check("relu_ch0", {wq[1].d1[7:0], wq[1].d2[7:0]}, {8'hF0, 8'h05});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
